// File: rtl/uart_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_pkg : shared encodings for the UART RX frame checker  r1.0 |
// +--------------------------------------------------------------------+
package uart_rx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DATA   = 3'd1;
  localparam logic [2:0] ST_PARITY = 3'd2;
  localparam logic [2:0] ST_STOP1  = 3'd3;
  localparam logic [2:0] ST_STOP2  = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP1  = ST_STOP1,
    S_STOP2  = ST_STOP2
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_sat_counter : saturating up-counter, clear wins        r1.0   |
// +--------------------------------------------------------------------+
module uart_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_frame_checker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_frame_checker : walks one RX frame, flags parity/stop/break r1.0 |
// +--------------------------------------------------------------------+
module uart_frame_checker
  import uart_rx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 bit_valid,
  input  logic                 sampled_bit,
  input  logic                 par_en,
  input  logic                 par_typ,
  input  logic                 two_stop,
  input  logic                 clr_cnt,
  output logic [DATA_W-1:0]    p_data,
  output logic                 frame_done,
  output logic                 data_valid,
  output logic                 par_err,
  output logic                 stp_err,
  output logic                 brk_det,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int              IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  rx_state_t         state;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift_q;
  logic              par_en_q;
  logic              par_typ_q;
  logic              two_stop_q;
  logic              par_bad;
  logic              stop_bad;
  logic              zero_acc;

  logic              final_bit;
  logic              fin_stp;
  logic              fin_brk;

  // Frame results are resolved on the last stop bit so every flag can be registered together.
  always_comb begin
    final_bit = bit_valid &&
                (((state == S_STOP1) && !two_stop_q) || (state == S_STOP2));
    fin_stp   = stop_bad | ~sampled_bit;
    fin_brk   = (state == S_STOP1) ? (zero_acc & ~sampled_bit) : zero_acc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      bit_idx    <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      two_stop_q <= 1'b0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      zero_acc   <= 1'b1;
      p_data     <= '0;
      frame_done <= 1'b0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      brk_det    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      brk_det    <= 1'b0;

      if (final_bit) begin
        frame_done <= 1'b1;
        p_data     <= shift_q;
        par_err    <= par_bad;
        stp_err    <= fin_stp;
        brk_det    <= fin_brk;
        data_valid <= ~(par_bad | fin_stp);
        state      <= S_IDLE;
        busy       <= 1'b0;
      end

      // A new start always wins: it aborts a partial frame or chains after a completed one.
      if (frame_start) begin
        state      <= S_DATA;
        busy       <= 1'b1;
        bit_idx    <= '0;
        par_en_q   <= par_en;
        par_typ_q  <= par_typ;
        two_stop_q <= two_stop;
        par_bad    <= 1'b0;
        stop_bad   <= 1'b0;
        zero_acc   <= 1'b1;
      end else if (bit_valid) begin
        case (state)
          S_DATA: begin
            shift_q  <= {sampled_bit, shift_q[DATA_W-1:1]};
            zero_acc <= zero_acc & ~sampled_bit;
            if (bit_idx == LAST_IDX) begin
              state <= par_en_q ? S_PARITY : S_STOP1;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
          S_PARITY: begin
            par_bad  <= sampled_bit ^ (^shift_q) ^ (par_typ_q == PAR_ODD);
            zero_acc <= zero_acc & ~sampled_bit;
            state    <= S_STOP1;
          end
          S_STOP1: begin
            stop_bad <= ~sampled_bit;
            zero_acc <= zero_acc & ~sampled_bit;
            if (two_stop_q) begin
              state <= S_STOP2;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  uart_sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (frame_done & ~data_valid),
    .clr (clr_cnt),
    .cnt (err_cnt)
  );

endmodule
`default_nettype wire
